// File: rtl/video_pkg.sv
// rtl/video_pkg.sv - shared types and defaults for the video fill arbiter
package video_pkg;

    localparam int ADDR_WIDTH_DEF = 15;
    localparam int DIM_WIDTH_DEF  = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        DONE = 2'd2
    } fill_state_e;

    typedef enum logic {
        HOST   = 1'b0,
        ENGINE = 1'b1
    } grant_owner_e;

endpackage

// File: rtl/rr_arbiter2.sv
// rtl/rr_arbiter2.sv - two-requester round-robin arbiter (host vs fill engine)
module rr_arbiter2
    import video_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic host_req,
    input  logic engine_req,
    output logic host_gnt,
    output logic engine_gnt
);

    grant_owner_e last_grant;

    // On contention the side that did not win last time gets the port.
    always_comb begin
        host_gnt   = host_req && (!engine_req || (last_grant == ENGINE));
        engine_gnt = engine_req && !host_gnt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant <= ENGINE;
        end else if (host_gnt) begin
            last_grant <= HOST;
        end else if (engine_gnt) begin
            last_grant <= ENGINE;
        end
    end

endmodule

// File: rtl/video_fill_arbiter.sv
// rtl/video_fill_arbiter.sv - shares the video memory port between host bus and rectangle-fill engine
module video_fill_arbiter
    import video_pkg::*;
#(
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
    parameter int DIM_WIDTH  = DIM_WIDTH_DEF
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  host_req,
    input  logic [3:0]            host_we,
    input  logic [15:0]           host_addr,
    input  logic [31:0]           host_wdata,
    output logic                  host_gnt,
    output logic                  host_rvalid,
    output logic [31:0]           host_rdata,
    input  logic                  cfg_start,
    input  logic [ADDR_WIDTH-1:0] cfg_base,
    input  logic [ADDR_WIDTH-1:0] cfg_stride,
    input  logic [DIM_WIDTH-1:0]  cfg_width,
    input  logic [DIM_WIDTH-1:0]  cfg_height,
    input  logic [31:0]           cfg_color,
    output logic                  busy,
    output logic                  done,
    output logic                  mem_en,
    output logic [3:0]            mem_we,
    output logic [15:0]           mem_addr,
    output logic [31:0]           mem_write,
    input  logic [31:0]           mem_read
);

    localparam logic [1:0] ST_IDLE = IDLE;
    localparam logic [1:0] ST_FILL = FILL;
    localparam logic [1:0] ST_DONE = DONE;

    localparam logic [DIM_WIDTH-1:0] DIM_ONE = 1;

    logic [1:0]            state;
    logic [DIM_WIDTH-1:0]  col;
    logic [DIM_WIDTH-1:0]  row;
    logic [ADDR_WIDTH-1:0] row_addr;
    logic [ADDR_WIDTH-1:0] stride_q;
    logic [DIM_WIDTH-1:0]  width_q;
    logic [DIM_WIDTH-1:0]  height_q;
    logic [31:0]           color_q;

    logic                  engine_req;
    logic                  engine_gnt;
    logic [ADDR_WIDTH-1:0] eng_addr;
    logic                  col_last;
    logic                  row_last;

    assign engine_req = (state == ST_FILL);
    assign busy       = (state == ST_FILL);
    assign done       = (state == ST_DONE);
    assign host_rdata = mem_read;

    // Address arithmetic wraps naturally at ADDR_WIDTH bits.
    assign eng_addr = row_addr + ADDR_WIDTH'(col);
    assign col_last = (col == (width_q - DIM_ONE));
    assign row_last = (row == (height_q - DIM_ONE));

    rr_arbiter2 u_arb (
        .clk        (clk),
        .rst_n      (rst_n),
        .host_req   (host_req),
        .engine_req (engine_req),
        .host_gnt   (host_gnt),
        .engine_gnt (engine_gnt)
    );

    always_comb begin
        mem_en    = 1'b0;
        mem_we    = 4'h0;
        mem_addr  = 16'h0000;
        mem_write = 32'h0000_0000;
        if (host_gnt) begin
            mem_en    = 1'b1;
            mem_we    = host_we;
            mem_addr  = host_addr;
            mem_write = host_wdata;
        end else if (engine_gnt) begin
            mem_en    = 1'b1;
            mem_we    = 4'hF;
            mem_addr  = {{(16-ADDR_WIDTH){1'b0}}, eng_addr};
            mem_write = color_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            host_rvalid <= 1'b0;
        end else begin
            host_rvalid <= host_gnt && (host_we == 4'h0);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            col      <= '0;
            row      <= '0;
            row_addr <= '0;
            stride_q <= '0;
            width_q  <= '0;
            height_q <= '0;
            color_q  <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (cfg_start) begin
                        stride_q <= cfg_stride;
                        width_q  <= cfg_width;
                        height_q <= cfg_height;
                        color_q  <= cfg_color;
                        col      <= '0;
                        row      <= '0;
                        row_addr <= cfg_base;
                        if ((cfg_width == '0) || (cfg_height == '0)) begin
                            state <= ST_DONE;
                        end else begin
                            state <= ST_FILL;
                        end
                    end
                end
                ST_FILL: begin
                    // Counters only move when the engine actually owned the port.
                    if (engine_gnt) begin
                        if (col_last) begin
                            col      <= '0;
                            row      <= row + DIM_ONE;
                            row_addr <= row_addr + stride_q;
                            if (row_last) begin
                                state <= ST_DONE;
                            end
                        end else begin
                            col <= col + DIM_ONE;
                        end
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_video_fill_arbiter.sv
// tb/tb_video_fill_arbiter.sv - directed self-checking bench for video_fill_arbiter
module tb_video_fill_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        host_req;
    logic [3:0]  host_we;
    logic [15:0] host_addr;
    logic [31:0] host_wdata;
    logic        host_gnt;
    logic        host_rvalid;
    logic [31:0] host_rdata;
    logic        cfg_start;
    logic [14:0] cfg_base;
    logic [14:0] cfg_stride;
    logic [7:0]  cfg_width;
    logic [7:0]  cfg_height;
    logic [31:0] cfg_color;
    logic        busy;
    logic        done;
    logic        mem_en;
    logic [3:0]  mem_we;
    logic [15:0] mem_addr;
    logic [31:0] mem_write;
    logic [31:0] mem_read;

    int checks   = 0;
    int failures = 0;
    int eng_idx;
    int writes;
    logic exp_h;

    logic [15:0] exp_fill [6] = '{16'h0100, 16'h0101, 16'h0102, 16'h0180, 16'h0181, 16'h0182};
    logic [15:0] exp_ign  [4] = '{16'h0200, 16'h0201, 16'h0210, 16'h0211};

    always #5 clk = ~clk;

    video_fill_arbiter dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .host_req    (host_req),
        .host_we     (host_we),
        .host_addr   (host_addr),
        .host_wdata  (host_wdata),
        .host_gnt    (host_gnt),
        .host_rvalid (host_rvalid),
        .host_rdata  (host_rdata),
        .cfg_start   (cfg_start),
        .cfg_base    (cfg_base),
        .cfg_stride  (cfg_stride),
        .cfg_width   (cfg_width),
        .cfg_height  (cfg_height),
        .cfg_color   (cfg_color),
        .busy        (busy),
        .done        (done),
        .mem_en      (mem_en),
        .mem_we      (mem_we),
        .mem_addr    (mem_addr),
        .mem_write   (mem_write),
        .mem_read    (mem_read)
    );

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%08h expected=0x%08h", tag, act, exp);
        end
    endtask

    task automatic start_fill(input logic [14:0] base, input logic [14:0] stride,
                              input logic [7:0] w, input logic [7:0] h, input logic [31:0] color);
        cfg_base   = base;
        cfg_stride = stride;
        cfg_width  = w;
        cfg_height = h;
        cfg_color  = color;
        cfg_start  = 1'b1;
    endtask

    initial begin
        rst_n      = 1'b0;
        host_req   = 1'b0;
        host_we    = 4'h0;
        host_addr  = 16'h0000;
        host_wdata = 32'h0;
        cfg_start  = 1'b0;
        cfg_base   = '0;
        cfg_stride = '0;
        cfg_width  = '0;
        cfg_height = '0;
        cfg_color  = '0;
        mem_read   = 32'hDEAD_BEEF;

        // reset state
        @(negedge clk); #1;
        check_val("rst_busy", busy, 0);
        check_val("rst_done", done, 0);
        check_val("rst_rvalid", host_rvalid, 0);
        check_val("rst_mem_en", mem_en, 0);
        check_val("rst_rdata", host_rdata, 32'hDEAD_BEEF);
        @(negedge clk); rst_n = 1'b1;

        // fill alone
        @(negedge clk);
        start_fill(15'h0100, 15'd128, 8'd3, 8'd2, 32'h00FF_0000);
        #1;
        check_val("fill_start_busy", busy, 0);
        check_val("fill_start_mem_en", mem_en, 0);
        for (int k = 0; k < 6; k++) begin
            @(negedge clk); cfg_start = 1'b0; #1;
            check_val($sformatf("fill_addr%0d", k), mem_addr, exp_fill[k]);
            check_val($sformatf("fill_we%0d", k), mem_we, 4'hF);
            check_val($sformatf("fill_data%0d", k), mem_write, 32'h00FF_0000);
            check_val($sformatf("fill_busy%0d", k), busy, 1);
            check_val($sformatf("fill_done%0d", k), done, 0);
        end
        @(negedge clk); #1;
        check_val("fill_done", done, 1);
        check_val("fill_done_busy", busy, 0);
        check_val("fill_done_mem_en", mem_en, 0);
        @(negedge clk); #1;
        check_val("fill_done_pulse", done, 0);

        // contention with a held host read
        @(negedge clk);
        start_fill(15'h0100, 15'd128, 8'd3, 8'd2, 32'h00FF_0000);
        #1;
        eng_idx = 0;
        writes  = 0;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            cfg_start = 1'b0;
            host_req  = 1'b1;
            host_we   = 4'h0;
            host_addr = 16'h0005;
            mem_read  = 32'hA5A5_0000 + k;
            #1;
            exp_h = (k % 2 == 1);
            check_val($sformatf("cont_hgnt%0d", k), host_gnt, exp_h);
            check_val($sformatf("cont_rvalid%0d", k), host_rvalid, (k > 1) && (k % 2 == 0));
            check_val($sformatf("cont_rdata%0d", k), host_rdata, 32'hA5A5_0000 + k);
            if (exp_h) begin
                check_val($sformatf("cont_haddr%0d", k), mem_addr, 16'h0005);
                check_val($sformatf("cont_hwe%0d", k), mem_we, 4'h0);
            end else begin
                check_val($sformatf("cont_eaddr%0d", k), mem_addr, exp_fill[eng_idx]);
                check_val($sformatf("cont_ewe%0d", k), mem_we, 4'hF);
                eng_idx++;
            end
            if (mem_en && mem_we == 4'hF) writes++;
        end
        @(negedge clk); #1;
        check_val("cont_done", done, 1);
        check_val("cont_done_hgnt", host_gnt, 1);
        check_val("cont_done_rvalid", host_rvalid, 0);
        @(negedge clk); host_req = 1'b0; #1;
        check_val("cont_last_rvalid", host_rvalid, 1);
        check_val("cont_idle_mem_en", mem_en, 0);
        check_val("cont_writes", writes, 6);

        // zero size
        @(negedge clk);
        start_fill(15'h0300, 15'd1, 8'd0, 8'd5, 32'h1111_1111);
        #1;
        check_val("zero_start_mem_en", mem_en, 0);
        @(negedge clk); cfg_start = 1'b0; #1;
        check_val("zero_done", done, 1);
        check_val("zero_busy", busy, 0);
        check_val("zero_mem_en", mem_en, 0);
        @(negedge clk); #1;
        check_val("zero_done_pulse", done, 0);
        check_val("zero_mem_en2", mem_en, 0);

        // address wrap
        @(negedge clk);
        start_fill(15'h7FFF, 15'd1, 8'd2, 8'd1, 32'hCAFE_F00D);
        @(negedge clk); cfg_start = 1'b0; #1;
        check_val("wrap_addr0", mem_addr, 16'h7FFF);
        @(negedge clk); #1;
        check_val("wrap_addr1", mem_addr, 16'h0000);
        check_val("wrap_data1", mem_write, 32'hCAFE_F00D);
        @(negedge clk); #1;
        check_val("wrap_done", done, 1);

        // ignored restart and cfg changes during fill
        @(negedge clk);
        start_fill(15'h0200, 15'h0010, 8'd2, 8'd2, 32'h1234_5678);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            cfg_start = (k == 1);
            if (k == 0) begin
                cfg_base   = 15'h3000;
                cfg_stride = 15'h0001;
                cfg_width  = 8'd9;
                cfg_height = 8'd9;
                cfg_color  = 32'h0;
            end
            #1;
            check_val($sformatf("ign_addr%0d", k), mem_addr, exp_ign[k]);
            check_val($sformatf("ign_data%0d", k), mem_write, 32'h1234_5678);
        end
        @(negedge clk); cfg_start = 1'b0; #1;
        check_val("ign_done", done, 1);
        @(negedge clk); #1;
        check_val("ign_no_restart_busy", busy, 0);
        check_val("ign_no_restart_mem_en", mem_en, 0);

        // reset mid-fill
        @(negedge clk);
        start_fill(15'h0400, 15'd16, 8'd4, 8'd4, 32'h5555_AAAA);
        @(negedge clk); cfg_start = 1'b0; #1;
        check_val("rstf_addr0", mem_addr, 16'h0400);
        @(negedge clk); #1;
        check_val("rstf_busy_pre", busy, 1);
        @(negedge clk); rst_n = 1'b0; #1;
        check_val("rstf_mem_en", mem_en, 0);
        check_val("rstf_busy", busy, 0);
        @(negedge clk); #1;
        check_val("rstf_done_held", done, 0);
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk); #1;
            check_val($sformatf("rstf_after_done%0d", k), done, 0);
            check_val($sformatf("rstf_after_en%0d", k), mem_en, 0);
        end
        @(negedge clk);
        start_fill(15'h0010, 15'd1, 8'd1, 8'd1, 32'h7777_0000);
        @(negedge clk); cfg_start = 1'b0; #1;
        check_val("rstf_new_addr", mem_addr, 16'h0010);
        check_val("rstf_new_data", mem_write, 32'h7777_0000);
        @(negedge clk); #1;
        check_val("rstf_new_done", done, 1);

        // control register access
        @(negedge clk);
        host_req   = 1'b1;
        host_we    = 4'hF;
        host_addr  = 16'h8000;
        host_wdata = 32'h0000_0040;
        #1;
        check_val("ctl_gnt", host_gnt, 1);
        check_val("ctl_mem_en", mem_en, 1);
        check_val("ctl_addr", mem_addr, 16'h8000);
        check_val("ctl_we", mem_we, 4'hF);
        check_val("ctl_data", mem_write, 32'h0000_0040);
        @(negedge clk); host_req = 1'b0; #1;
        check_val("ctl_no_rvalid", host_rvalid, 0);
        check_val("ctl_idle_en", mem_en, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/video_fill_arbiter.md
Name: video_fill_arbiter

Overview:
- Shares the video memory port of video_unit (mem_en/mem_we/mem_addr/mem_write/mem_read, 1-cycle read latency) between the host bus and an internal rectangle-fill engine.
- The fill engine writes a constant 32-bit colour into a width x height word rectangle of video memory at a programmable base and stride. It lets software clear or paint regions without spending CPU bus cycles.
- Sits between the host bus adapter and video_unit, in the mem_clk domain.

Parameters:
ADDR_WIDTH, 15, word-address width of the video memory region; engine addresses wrap modulo 2**ADDR_WIDTH
DIM_WIDTH, 8, width of the rectangle width/height counters

Ports:
clk  in  1  clock (video_unit mem_clk)
rst_n  in  1  reset, asynchronous, active-low
host_req  in  1  host access request, held until host_gnt
host_we  in  4  host byte write enables; 0 = read
host_addr  in  16  host address; bit 15 = 1 selects video_unit control registers
host_wdata  in  32  host write data
host_gnt  out  1  host access issued to memory this cycle
host_rvalid  out  1  host_rdata valid; one cycle after a granted read
host_rdata  out  32  read data (mem_read passthrough)
cfg_start  in  1  start fill; sampled only in IDLE
cfg_base  in  ADDR_WIDTH  first word address
cfg_stride  in  ADDR_WIDTH  word distance between rows
cfg_width  in  DIM_WIDTH  words per row
cfg_height  in  DIM_WIDTH  row count
cfg_color  in  32  fill word
busy  out  1  engine in FILL
done  out  1  one-cycle pulse at fill completion
mem_en  out  1  to video_unit
mem_we  out  4  to video_unit
mem_addr  out  16  to video_unit
mem_write  out  32  to video_unit
mem_read  in  32  from video_unit

Behaviour:
- Reset (async, rst_n low): state IDLE. busy, done, host_rvalid = 0. Row/column counters = 0. last_grant = ENGINE, so the host wins the first contention.
- mem_*, host_gnt: combinational from the arbitration of the current cycle.
  - No grant: mem_en = 0, mem_we = 0, mem_addr = 0, mem_write = 0.
  - host_rdata = mem_read at all times.
- Arbitration, each cycle:
  - Only host requests -> grant host.
  - Only engine requests -> grant engine.
  - Both request -> grant the requester that was not last_grant (round-robin).
  - last_grant updates on every grant.
  - Host is never starved; it waits at most 1 cycle behind the engine.
- Host grant: mem_en = 1, mem_we = host_we, mem_addr = host_addr, mem_write = host_wdata. host_rvalid = 1 the next cycle iff host_we == 0.
- Engine grant: mem_en = 1, mem_we = 4'hF, mem_addr = {1'b0, row_addr + col}, truncated to ADDR_WIDTH (wrap), mem_write = colour latched at start.
- FSM:
  - IDLE: on cfg_start, latch base/stride/width/height/colour, set col = 0, row = 0, row_addr = base.
    - If width == 0 or height == 0 -> DONE (no writes).
    - Else -> FILL.
  - FILL: busy = 1; engine requests every cycle. Counters advance only on engine grant.
    - col == width-1: col = 0, row_addr += stride (mod 2**ADDR_WIDTH), row++.
    - Otherwise col++.
    - Grant of element (width-1, height-1) -> DONE.
  - DONE: done = 1 for exactly one cycle, busy = 0 -> IDLE.
- cfg_start outside IDLE is ignored. cfg_* changes during FILL have no effect.
- Total engine writes = width*height exactly. With no host traffic, throughput is 1 write/cycle: done is asserted width*height+1 cycles after the start cycle.
- Host requests with host_addr[15] = 1 are arbitrated identically to memory accesses.
- Reset during FILL aborts immediately. No further engine writes; no done pulse.

Decomposition:
- Package video_pkg: fill FSM state enum (IDLE, FILL, DONE), grant-owner enum (HOST, ENGINE), ADDR_WIDTH/DIM_WIDTH defaults.
- One natural sub-module: rr_arbiter2, a two-requester round-robin arbiter with a last_grant register. The fill FSM and datapath stay in the top module.

Test Plan:
- Fill alone: base=0x0100, stride=128, width=3, height=2, colour=0x00FF0000, start -> writes at 0x0100,0x0101,0x0102,0x0180,0x0181,0x0182 on consecutive cycles, all we=F; done 7 cycles after start; busy high 6 cycles.
- Contention: host holds req (read 0x0005) during the above fill -> grants alternate host/engine starting with host; host_rvalid 1 cycle after each host grant; fill completes with exactly 6 writes.
- Zero size: width=0, height=5, start -> no mem_en from engine; done pulses the cycle after start; busy never asserts.
- Wrap: base=0x7FFF, stride=1, width=2, height=1 -> writes at mem_addr 0x7FFF then 0x0000; bit 15 never set by engine.
- Ignored start/reset: cfg_start pulsed again mid-fill -> no restart, original count completes. Separate run: rst_n low mid-fill -> mem_en=0, busy=0 asynchronously, no done pulse, next start runs normally.
- Control access: host write we=F addr=0x8000 data=0x40 while idle -> mem_addr=0x8000, mem_we=F same cycle as host_gnt, no host_rvalid.
